// File: rtl/net_pkg.sv
// Shared constants, state encoding and helpers for the W5500 streaming transmitter.
package net_pkg;

    // W5500 control-phase fields: socket TX buffer block offset, write, variable-length mode.
    localparam int         BSB_TXBUF = 2;
    localparam logic       RWB_WRITE = 1'b1;
    localparam logic [1:0] OM_VDM    = 2'b00;

    // Transmit FSM encoding (kept as plain constants for legacy tool flows).
    typedef logic [2:0] state_t;
    localparam state_t ST_RST_HOLD = 3'd0;
    localparam state_t ST_RST_WAIT = 3'd1;
    localparam state_t ST_IDLE     = 3'd2;
    localparam state_t ST_CS_SETUP = 3'd3;
    localparam state_t ST_SHIFT    = 3'd4;
    localparam state_t ST_CS_HOLD  = 3'd5;
    localparam state_t ST_GAP      = 3'd6;

    // Number of whole bytes needed to carry a sample of width w.
    function automatic int net_bytes(input int w);
        return (w + 7) / 8;
    endfunction

    // Control byte addressing the TX buffer block of the given socket.
    function automatic logic [7:0] net_ctrl_byte(input int socket);
        return {5'(4 * socket + BSB_TXBUF), RWB_WRITE, OM_VDM};
    endfunction

endpackage

// File: rtl/net_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered ready flag.
module net_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_ready;
    logic [PTR_W:0]    w_count_next;
    logic              w_push;
    logic              w_pop;

    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_ready   = r_ready;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_count_next unassigned (that would infer a latch).
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Sample storage write port.
    // NOTE: the array has no reset; only pointers and count need one, and an unreset array maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, count and the registered ready flag (low while in reset).
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != (PTR_W + 1)'(DEPTH));
        end
    end

endmodule

// File: rtl/net_stream_tx.sv
// Streams buffered sensor samples into a W5500 socket TX buffer, one VDM SPI write per sample.
module net_stream_tx
    import net_pkg::*;
#(
    parameter int          DATA_W     = 19,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CLK_DIV    = 2,
    parameter int          SOCKET     = 0,
    parameter int          RST_CYC    = 1000,
    parameter int          RDY_CYC    = 50000,
    parameter int          GAP_CYC    = 4,
    parameter logic [15:0] ADDR_RST   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              o_spi_cs,
    output logic              o_spi_sck,
    output logic              o_spi_mosi,
    output logic              o_w5500_rst,
    output logic              busy,
    output logic              frame_done
);

    localparam int BYTES   = net_bytes(DATA_W);
    localparam int PAD_W   = BYTES * 8;
    localparam int FRAME_W = (3 + BYTES) * 8;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [7:0]       CTRL_BYTE = net_ctrl_byte(SOCKET);
    localparam logic [31:0]      RST_LAST  = 32'(RST_CYC - 1);
    localparam logic [31:0]      RDY_LAST  = 32'(RDY_CYC - 1);
    localparam logic [31:0]      GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

    state_t             r_state;
    logic [31:0]        r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [FRAME_W-1:0] r_shift;
    logic [15:0]        r_addr;
    logic               r_cs;
    logic               r_sck;
    logic               r_mosi;
    logic               r_w5500_rst;
    logic               r_frame_done;

    logic [DATA_W-1:0]  w_fifo_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_half_end;
    logic [PAD_W-1:0]   w_sample_pad;

    assign w_push       = data_valid && data_ready && !w_fifo_full;
    assign w_pop        = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_half_end   = (r_div == DIV_LAST);
    assign w_sample_pad = PAD_W'(w_fifo_data);

    assign o_spi_cs     = r_cs;
    assign o_spi_sck    = r_sck;
    assign o_spi_mosi   = r_mosi;
    assign o_w5500_rst  = r_w5500_rst;
    assign frame_done   = r_frame_done;
    assign busy         = (r_state == ST_CS_SETUP) || (r_state == ST_SHIFT) ||
                          (r_state == ST_CS_HOLD)  || (r_state == ST_GAP);

    net_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (data_in),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_ready   (data_ready)
    );

    // Reset sequencing, frame FSM, SCK half-period divider, bit counter, shifter and address pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RST_HOLD;
            r_cnt        <= '0;
            r_div        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_addr       <= ADDR_RST;
            r_cs         <= 1'b1;
            r_sck        <= 1'b0;
            r_mosi       <= 1'b0;
            r_w5500_rst  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_RST_HOLD: begin
                    if (r_cnt == RST_LAST) begin
                        r_cnt       <= '0;
                        r_w5500_rst <= 1'b1;
                        r_state     <= ST_RST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RST_WAIT: begin
                    if (r_cnt == RDY_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    // Pop and load the whole frame in one cycle; CS falls on the same edge.
                    if (w_pop) begin
                        r_shift <= {r_addr, CTRL_BYTE, w_sample_pad};
                        r_cs    <= 1'b0;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_state <= ST_CS_SETUP;
                    end
                end

                ST_CS_SETUP: begin
                    if (w_half_end) begin
                        // First bit appears at the start of the first SCK-low half.
                        r_div   <= '0;
                        r_mosi  <= r_shift[FRAME_W-1];
                        r_state <= ST_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (w_half_end) begin
                        r_div <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else if (r_bit == BIT_LAST) begin
                            r_sck   <= 1'b0;
                            r_mosi  <= 1'b0;
                            r_state <= ST_CS_HOLD;
                        end else begin
                            // Falling SCK: advance to the next bit while SCK is low.
                            r_sck   <= 1'b0;
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift << 1;
                            r_mosi  <= r_shift[FRAME_W-2];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                ST_CS_HOLD: begin
                    if (w_half_end) begin
                        r_div        <= '0;
                        r_cs         <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_addr       <= r_addr + 16'(BYTES);
                        r_cnt        <= '0;
                        r_state      <= ST_GAP;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_RST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_net_stream_tx.sv
// Scoreboard bench: two transmitter instances, frames decoded from the SPI pins and
// compared against hand-computed expected frames queued at stimulus time.
module tb_net_stream_tx;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [18:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic        cs_a, cs_b, sck_a, sck_b, mosi_a, mosi_b;
    logic        wrst_a, wrst_b, busy_a, busy_b, fd_a, fd_b;

    always #5 clk = ~clk;

    // Instance A: socket 0, depth 8, address from 0x0000.
    net_stream_tx #(
        .DATA_W(19), .FIFO_DEPTH(8), .CLK_DIV(2), .SOCKET(0),
        .RST_CYC(10), .RDY_CYC(20), .GAP_CYC(4), .ADDR_RST(16'h0000)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .data_in(data_a), .data_valid(valid_a),
        .data_ready(ready_a), .o_spi_cs(cs_a), .o_spi_sck(sck_a),
        .o_spi_mosi(mosi_a), .o_w5500_rst(wrst_a), .busy(busy_a),
        .frame_done(fd_a)
    );

    // Instance B: socket 3, depth 4, pointer preloaded to 0xFFFF (state after 21845 3-byte frames).
    net_stream_tx #(
        .DATA_W(19), .FIFO_DEPTH(4), .CLK_DIV(2), .SOCKET(3),
        .RST_CYC(10), .RDY_CYC(20), .GAP_CYC(4), .ADDR_RST(16'hFFFF)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .data_in(data_b), .data_valid(valid_b),
        .data_ready(ready_b), .o_spi_cs(cs_b), .o_spi_sck(sck_b),
        .o_spi_mosi(mosi_b), .o_w5500_rst(wrst_b), .busy(busy_b),
        .frame_done(fd_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues and monitor state, index 0 = A, 1 = B.
    logic [47:0] exp_a[$];
    logic [47:0] exp_b[$];
    int          falls_b[$];
    logic [1:0]  m_cs, m_sck, m_mosi, m_fd;
    logic [1:0]  p_cs = 2'b11, p_sck = 2'b00, p_mosi = 2'b00, p2_mosi = 2'b00;
    int          bits[2], start[2], viol[2], frames[2];
    logic [63:0] shv[2];
    bit          abort[2];
    int          cyc = 0;

    assign m_cs   = {cs_b, cs_a};
    assign m_sck  = {sck_b, sck_a};
    assign m_mosi = {mosi_b, mosi_a};
    assign m_fd   = {fd_b, fd_a};

    // Monitor: decodes each CS-framed transfer on the falling clock edge and scores it.
    always @(negedge clk) begin
        logic [47:0] e;
        bit          have;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (p_cs[i] && !m_cs[i]) begin
                bits[i]  = 0;
                shv[i]   = '0;
                viol[i]  = 0;
                start[i] = cyc;
                if (i == 1) falls_b.push_back(cyc);
            end
            if (!m_cs[i]) begin
                if (m_sck[i] && (m_mosi[i] !== p_mosi[i])) viol[i]++;
                if (m_sck[i] && !p_sck[i]) begin
                    if (m_mosi[i] !== p2_mosi[i]) viol[i]++;
                    shv[i] = {shv[i][62:0], m_mosi[i]};
                    bits[i]++;
                end
            end
            if (!p_cs[i] && m_cs[i]) begin
                if (!abort[i]) begin
                    check($sformatf("bits_%0d", i), bits[i], 48);
                    check($sformatf("frame_len_%0d", i), cyc - start[i], 196);
                    check($sformatf("frame_done_%0d", i), m_fd[i], 1);
                    check($sformatf("mosi_stable_%0d", i), viol[i], 0);
                    have = 1'b0;
                    e    = '0;
                    if (i == 0 && exp_a.size() > 0) begin have = 1'b1; e = exp_a.pop_front(); end
                    if (i == 1 && exp_b.size() > 0) begin have = 1'b1; e = exp_b.pop_front(); end
                    n_checks++;
                    if (!have) begin
                        n_fail++;
                        $display("FAIL frame_unexpected_%0d: got 0x%012h expected none", i, shv[i][47:0]);
                    end else if (shv[i][47:0] !== e) begin
                        n_fail++;
                        $display("FAIL frame_data_%0d: got 0x%012h expected 0x%012h", i, shv[i][47:0], e);
                    end
                    frames[i]++;
                end
            end else if (m_fd[i]) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_done_stray_%0d: got 1 expected 0", i);
            end
            p2_mosi[i] = p_mosi[i];
            p_mosi[i]  = m_mosi[i];
            p_sck[i]   = m_sck[i];
            p_cs[i]    = m_cs[i];
        end
    end

    task automatic wait_frames(input int inst, input int n, input int budget, input string name);
        int t = 0;
        while (frames[inst] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, frames[inst], n);
    endtask

    // Hand-computed frames for B: {addr, ctrl 0x74, 0x0 & sample}, address wraps 0xFFFF -> 0x0002.
    logic [47:0] exp_frames_b[4] = '{48'hFFFF_74_011111, 48'h0002_74_022222,
                                     48'h0005_74_033333, 48'h0008_74_044444};

    int k, rst_len;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);

        check("rst_cs", cs_a, 1);
        check("rst_sck", sck_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_w5500", wrst_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_frame_done", fd_a, 0);

        // Reset sequence and first frame (sample pushed during RST_WAIT).
        rst_a = 1'b0;
        k = 0; rst_len = -1;
        while (cs_a && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) check("ready_after_rst", ready_a, 1);
            if (wrst_a && rst_len < 0) rst_len = k;
            if (k == 12) begin
                data_a = 19'h5A5A5; valid_a = 1'b1;
                exp_a.push_back(48'h0000_14_05A5A5);
            end else begin
                valid_a = 1'b0;
            end
        end
        valid_a = 1'b0;
        check("w5500_rst_low_cycles", rst_len, 10);
        check("first_cs_fall_cycle", k, 31);
        check("busy_in_frame", busy_a, 1);
        wait_frames(0, 1, 400, "frames_a_1");

        // Address increment and push-to-CS latency from IDLE.
        repeat (10) @(negedge clk);
        check("busy_idle", busy_a, 0);
        data_a = 19'h00001; valid_a = 1'b1;
        exp_a.push_back(48'h0003_14_000001);
        k = 0;
        while (cs_a && k < 10) begin
            @(negedge clk);
            valid_a = 1'b0;
            k++;
        end
        check("push_to_cs_latency", k, 2);
        wait_frames(0, 2, 400, "frames_a_2");

        // Reset mid-frame: one frame shifting, one sample queued behind it.
        repeat (10) @(negedge clk);
        data_a = 19'h12345; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        k = 0;
        while (cs_a && k < 10) begin @(negedge clk); k++; end
        repeat (40) @(negedge clk);
        data_a = 19'h2AAAA; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (5) @(negedge clk);
        check("sck_before_abort_in_shift", busy_a, 1);
        abort[0] = 1'b1;
        rst_a = 1'b1;
        #1;
        check("abort_cs", cs_a, 1);
        check("abort_sck", sck_a, 0);
        check("abort_mosi", mosi_a, 0);
        check("abort_w5500", wrst_a, 0);
        check("abort_ready", ready_a, 0);
        check("abort_busy", busy_a, 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        abort[0] = 1'b0;
        k = 0;
        while (cs_a && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                data_a = 19'h00ABC; valid_a = 1'b1;
                exp_a.push_back(48'h0000_14_000ABC);
            end else begin
                valid_a = 1'b0;
            end
        end
        valid_a = 1'b0;
        check("cs_fall_after_abort", k, 31);
        wait_frames(0, 3, 400, "frames_a_3");

        // Instance B: six back-to-back pushes into a depth-4 FIFO during RST_WAIT.
        rst_b = 1'b0;
        k = 0;
        while (cs_b && k < 200) begin
            @(negedge clk);
            k++;
            valid_b = 1'b0;
            if (k >= 15 && k <= 20) begin
                check($sformatf("ready_b_push%0d", k - 14), ready_b, (k <= 18) ? 1 : 0);
                data_b  = 19'(k - 14) * 19'h11111;
                valid_b = 1'b1;
                if (k <= 18) exp_b.push_back(exp_frames_b[k - 15]);
            end
        end
        valid_b = 1'b0;
        check("b_first_cs_fall", k, 31);
        wait_frames(1, 4, 1200, "frames_b_4");
        repeat (400) @(negedge clk);
        check("frames_b_exact", frames[1], 4);
        check("falls_b_count", falls_b.size(), 4);
        for (int i = 1; i < 4 && i < falls_b.size(); i++) begin
            check($sformatf("b_frame_period_%0d", i), falls_b[i] - falls_b[i-1], 201);
        end
        check("ready_b_drained", ready_b, 1);
        check("exp_a_left", exp_a.size(), 0);
        check("exp_b_left", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog: ends the run if the main sequence stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
